power_bar_gen: RTL and testbench
================================

// Module: power_bar_gen
// PURPOSE
//  Upstream neighbour of the background drawing stage. Generates the throw-power bar overlay
//  (bar_on, rgb_bar) from the same VGA timing inputs, one cycle late to match the stage's
//  one-cycle background-ROM delay. Hosts the charge state machine:
//  - hold fire: power ping-pongs 0..MAX_POWER, one step per frame;
//  - release: latches the shot power for the throw logic.
// PARAMETERS
//  BAR_X       100  left x of bar outline (pixels, 11 b)
//  BAR_Y       700  top y of bar outline (pixels, 11 b)
//  BAR_H       16   outline height incl. 1-px border
//  MAX_POWER   100  power ceiling (7 b); outline width = MAX_POWER*PX_PER_UNIT+2
//  PX_PER_UNIT 2    fill pixels per power unit
//  SHOW_FRAMES 60   frames the fired power remains displayed
// PORTS
//  clk         in   1   pixel clock
//  rst         in   1   synchronous, active-high reset
//  hcount_in   in   11  horizontal pixel counter
//  vcount_in   in   11  vertical line counter
//  hblnk_in    in   1   horizontal blank
//  vblnk_in    in   1   vertical blank
//  enable      in   1   current player may throw (level)
//  btn_fire    in   1   fire button, already synchronised/debounced (level)
//  bar_on      out  1   pixel belongs to bar (border or fill); registered
//  rgb_bar     out  12  bar colour for that pixel; 12'h000 when bar_on=0
//  power       out  7   current power value
//  shot_valid  out  1   one-cycle pulse on release
//  shot_power  out  7   power latched on release; holds until next release
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal direction = up. Reset mid-charge aborts the shot
//   with no shot_valid pulse.
//  Frame tick: 1-cycle pulse when vblnk_in is 1 and its registered copy is 0.
//   - power/fill change only on a tick, so the bar never tears mid-frame.
//  Button events: rise/fall detected against registered btn_fire; the register resets to 0.
//  FSM:
//   IDLE   power=0. On btn rise && enable -> CHARGE, dir=up.
//   CHARGE On tick: power += dir ? 1 : -1.
//          - reaching MAX_POWER sets dir=down; reaching 0 sets dir=up.
//          - power never exceeds MAX_POWER or underflows.
//          On btn fall: shot_valid=1 next cycle, shot_power=power (pre-tick value if the fall
//          coincides with a tick; that tick is ignored) -> SHOW, frame counter=0.
//          enable fall (priority over btn fall in the same cycle) -> IDLE, power=0, no pulse.
//   SHOW   power frozen. Frame counter increments per tick; at SHOW_FRAMES -> IDLE, power=0.
//          Button ignored.
//  Pixel path (1-cycle registered latency from hcount_in/vcount_in):
//   - in_box: BAR_X <= h < BAR_X+MAX_POWER*PX_PER_UNIT+2 and BAR_Y <= v < BAR_Y+BAR_H.
//   - border = in_box && (first/last column or row of the box) -> rgb_bar=12'hFFF.
//   - fill = in_box && !border && (h-BAR_X-1) < fill_px.
//     - fill_px = power*PX_PER_UNIT, registered on the tick/state change (11 b, no overflow).
//     - colour: power*10 < MAX_POWER*5 -> 12'h0F0; < MAX_POWER*8 -> 12'hFF0; else 12'hF00.
//   - Interior not filled: bar_on=0.
//   - bar_on=0 whenever hblnk_in||vblnk_in.
//   - Comparisons are unsigned 11 b; h<BAR_X must not wrap into fill.
// TESTING
//  1. rst mid-CHARGE (power=37) -> next cycle all outputs 0, IDLE, no shot_valid.
//  2. enable=1, press, hold 120 frames -> power 0..100 by frame 100, then 99..80 at frame 120.
//  3. Release at power=42 -> single shot_valid pulse, shot_power=42; power holds 42 for
//     60 frames, then 0.
//  4. Release and tick in same cycle at power=10 -> shot_power=10, power stays 10.
//  5. power=50, h=BAR_X+1..BAR_X+100 on row BAR_Y+5 -> bar_on=1, rgb_bar=12'hFF0, one cycle
//     after input; h=BAR_X+101 -> bar_on=0.
//  6. Border pixel (BAR_X,BAR_Y) -> 12'hFFF; same pixel with vblnk_in=1 -> bar_on=0.
//     Press with enable=0 -> stays IDLE.

Source files
------------

// File: rtl/power_bar_gen_if.sv
// power_bar_gen_if
//  Groups the signals between the power bar generator and its neighbours.
//  VGA timing and player controls flow in. The bar pixel and the shot
//  information flow out.
//  Signals:
//   hcount_in  [10:0]  horizontal pixel counter
//   vcount_in  [10:0]  vertical line counter
//   hblnk_in           horizontal blank
//   vblnk_in           vertical blank
//   enable             current player may throw (level)
//   btn_fire           fire button, synchronised/debounced (level)
//   bar_on             pixel belongs to the bar (border or fill)
//   rgb_bar    [11:0]  bar colour for that pixel
//   power      [6:0]   current power value
//   shot_valid         one-cycle pulse on release
//   shot_power [6:0]   power latched on release
//  Modports:
//   master  drives timing and controls, and observes the bar outputs
//   slave   the generator itself
interface power_bar_gen_if;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic        enable;
  logic        btn_fire;
  logic        bar_on;
  logic [11:0] rgb_bar;
  logic [6:0]  power;
  logic        shot_valid;
  logic [6:0]  shot_power;

  modport master (
    output hcount_in, vcount_in, hblnk_in, vblnk_in, enable, btn_fire,
    input  bar_on, rgb_bar, power, shot_valid, shot_power
  );

  modport slave (
    input  hcount_in, vcount_in, hblnk_in, vblnk_in, enable, btn_fire,
    output bar_on, rgb_bar, power, shot_valid, shot_power
  );
endinterface

// File: rtl/power_bar_gen.sv
// power_bar_gen
//  Draws the throw-power bar overlay. The overlay is one cycle late, which
//  matches the background stage's ROM delay. The module also runs the charge
//  state machine:
//   - While fire is held, power ping-pongs between 0 and MAX_POWER, one step
//     per frame.
//   - On release, the power is latched for the throw logic. The power is then
//     displayed for SHOW_FRAMES frames.
//  Ports:
//   clk   pixel clock
//   rst   synchronous, active-high reset
//   bus   power_bar_gen_if.slave: timing and controls in; bar pixel,
//         power and shot out
module power_bar_gen #(
  parameter logic [10:0] BAR_X       = 11'd100,
  parameter logic [10:0] BAR_Y       = 11'd700,
  parameter logic [10:0] BAR_H       = 11'd16,
  parameter logic [6:0]  MAX_POWER   = 7'd100,
  parameter logic [10:0] PX_PER_UNIT = 11'd2,
  parameter logic [6:0]  SHOW_FRAMES = 7'd60
) (
  input  logic            clk,
  input  logic            rst,
  power_bar_gen_if.slave  bus
);

  // Outline spans the full fill width plus a one-pixel border on each side.
  localparam logic [10:0] BAR_W      = 11'(MAX_POWER) * PX_PER_UNIT + 11'd2;
  localparam logic [10:0] BOX_RIGHT  = BAR_X + BAR_W - 11'd1;
  localparam logic [10:0] BOX_BOTTOM = BAR_Y + BAR_H - 11'd1;
  localparam logic [10:0] GREEN_LIM  = 11'(MAX_POWER) * 11'd5;
  localparam logic [10:0] YELLOW_LIM = 11'(MAX_POWER) * 11'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    SHOW   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [6:0]  power_q, power_d;
  logic [6:0]  frame_cnt_q, frame_cnt_d;
  logic        shot_valid_q, shot_valid_d;
  logic [6:0]  shot_power_q, shot_power_d;
  logic        vblnk_q, vblnk_d;
  logic        btn_q, btn_d;
  logic [10:0] fill_px_q, fill_px_d;
  logic        bar_on_q, bar_on_d;
  logic [11:0] rgb_q, rgb_d;

  logic        tick;
  logic        btn_rise;
  logic        btn_fall;

  // Edge detectors.
  //  - tick marks the start of vertical blank. Power and fill only move on
  //    this edge, so the bar never tears mid-frame.
  always_comb begin
    vblnk_d  = bus.vblnk_in;
    btn_d    = bus.btn_fire;
    tick     = bus.vblnk_in && !vblnk_q;
    btn_rise = bus.btn_fire && !btn_q;
    btn_fall = !bus.btn_fire && btn_q;
  end

  // Charge state machine: next state and power.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    power_d      = power_q;
    frame_cnt_d  = frame_cnt_q;
    shot_valid_d = 1'b0;
    shot_power_d = shot_power_q;
    unique case (state_q)
      IDLE: begin
        power_d = 7'd0;
        if (btn_rise && bus.enable) begin
          state_d = CHARGE;
          dir_d   = 1'b1;
        end
      end
      CHARGE: begin
        // Losing enable aborts the throw and takes priority over a release.
        // A release wins over a coincident tick, so the shot keeps the
        // power the player saw.
        if (!bus.enable) begin
          state_d = IDLE;
          power_d = 7'd0;
        end else if (btn_fall) begin
          state_d      = SHOW;
          shot_valid_d = 1'b1;
          shot_power_d = power_q;
          frame_cnt_d  = 7'd0;
        end else if (tick) begin
          if (dir_q) begin
            if (power_q >= MAX_POWER - 7'd1) begin
              power_d = MAX_POWER;
              dir_d   = 1'b0;
            end else begin
              power_d = power_q + 7'd1;
            end
          end else begin
            if (power_q <= 7'd1) begin
              power_d = 7'd0;
              dir_d   = 1'b1;
            end else begin
              power_d = power_q - 7'd1;
            end
          end
        end
      end
      SHOW: begin
        if (tick) begin
          if (frame_cnt_q + 7'd1 >= SHOW_FRAMES) begin
            state_d     = IDLE;
            power_d     = 7'd0;
            frame_cnt_d = 7'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 7'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        power_d = 7'd0;
      end
    endcase
    // Fill width follows power. It therefore only changes on a tick or on a
    // state change.
    fill_px_d = 11'(power_d) * PX_PER_UNIT;
  end

  // Pixel path.
  //  - The fill test subtracts only after in_box and !border hold, so
  //    h >= BAR_X + 1 and the subtraction cannot wrap.
  //  - power_q and fill_px_q update together, so the colour and the width
  //    always describe the same power.
  always_comb begin
    logic [10:0] h;
    logic [10:0] v;
    logic        in_box;
    logic        border;
    logic        fill;
    logic [10:0] power_x10;
    h         = bus.hcount_in;
    v         = bus.vcount_in;
    in_box    = (h >= BAR_X) && (h <= BOX_RIGHT) && (v >= BAR_Y) && (v <= BOX_BOTTOM);
    border    = in_box && ((h == BAR_X) || (h == BOX_RIGHT) ||
                           (v == BAR_Y) || (v == BOX_BOTTOM));
    fill      = in_box && !border && ((h - BAR_X - 11'd1) < fill_px_q);
    power_x10 = 11'(power_q) * 11'd10;
    bar_on_d  = 1'b0;
    rgb_d     = 12'h000;
    if (!(bus.hblnk_in || bus.vblnk_in)) begin
      if (border) begin
        bar_on_d = 1'b1;
        rgb_d    = 12'hFFF;
      end else if (fill) begin
        bar_on_d = 1'b1;
        if (power_x10 < GREEN_LIM) begin
          rgb_d = 12'h0F0;
        end else if (power_x10 < YELLOW_LIM) begin
          rgb_d = 12'hFF0;
        end else begin
          rgb_d = 12'hF00;
        end
      end
    end
  end

  // State register. Reset abandons any charge in progress without a shot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dir_q        <= 1'b1;
      power_q      <= 7'd0;
      frame_cnt_q  <= 7'd0;
      shot_valid_q <= 1'b0;
      shot_power_q <= 7'd0;
      vblnk_q      <= 1'b0;
      btn_q        <= 1'b0;
      fill_px_q    <= 11'd0;
      bar_on_q     <= 1'b0;
      rgb_q        <= 12'h000;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      power_q      <= power_d;
      frame_cnt_q  <= frame_cnt_d;
      shot_valid_q <= shot_valid_d;
      shot_power_q <= shot_power_d;
      vblnk_q      <= vblnk_d;
      btn_q        <= btn_d;
      fill_px_q    <= fill_px_d;
      bar_on_q     <= bar_on_d;
      rgb_q        <= rgb_d;
    end
  end

  assign bus.bar_on     = bar_on_q;
  assign bus.rgb_bar    = rgb_q;
  assign bus.power      = power_q;
  assign bus.shot_valid = shot_valid_q;
  assign bus.shot_power = shot_power_q;

endmodule

// File: tb/tb_power_bar_gen.sv
// tb_power_bar_gen
//  Directed bench for power_bar_gen.
//  - Stimulus pushes expected values into queues.
//  - A monitor on the falling clock edge pops and compares them.
//  - Every shot_valid pulse is matched against a queue of expected shot
//    powers. An unexpected pulse is a failure, and so is a missing pulse.
module tb_power_bar_gen;

  localparam logic [10:0] BAR_X = 11'd100;
  localparam logic [10:0] BAR_Y = 11'd700;

  localparam int SEL_POWER = 0;
  localparam int SEL_ON    = 1;
  localparam int SEL_RGB   = 2;
  localparam int SEL_SPWR  = 3;
  localparam int SEL_SVLD  = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [11:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  power_bar_gen_if bus();

  power_bar_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [6:0] shot_q[$];
  int         n_total = 0;
  int         n_bad   = 0;

  function automatic logic [11:0] dut_val(int sel);
    case (sel)
      SEL_POWER: return {5'd0, bus.power};
      SEL_ON:    return {11'd0, bus.bar_on};
      SEL_RGB:   return bus.rgb_bar;
      SEL_SPWR:  return {5'd0, bus.shot_power};
      default:   return {11'd0, bus.shot_valid};
    endcase
  endfunction

  // Monitor: checks queued expectations and every shot pulse.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_total++;
      if (dut_val(e.sel) !== e.exp) begin
        n_bad++;
        $display("[TB] FAIL %s: got %h want %h", e.name, dut_val(e.sel), e.exp);
      end
    end
    if (bus.shot_valid === 1'b1) begin
      n_total++;
      if (shot_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_shot: got shot_power %0d want no pulse", bus.shot_power);
      end else begin
        logic [6:0] sp;
        sp = shot_q.pop_front();
        if (bus.shot_power !== sp) begin
          n_bad++;
          $display("[TB] FAIL shot_power: got %0d want %0d", bus.shot_power, sp);
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(string name, int sel, logic [11:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(logic [10:0] h, logic [10:0] v, logic hb, logic vb);
    bus.hcount_in = h;
    bus.vcount_in = v;
    bus.hblnk_in  = hb;
    bus.vblnk_in  = vb;
  endtask

  // One short frame: a single vblank-rise tick, then active video.
  task automatic frame();
    bus.vblnk_in = 1'b1;
    step();
    bus.vblnk_in = 1'b0;
    step(2);
  endtask

  // Present a pixel and check the registered result one cycle later.
  task automatic pix(string name, logic [10:0] h, logic [10:0] v, logic hb, logic vb,
                     logic exp_on, logic [11:0] exp_rgb);
    apply_stimulus(h, v, hb, vb);
    step();
    check_output({name, "_on"}, SEL_ON, {11'd0, exp_on});
    check_output({name, "_rgb"}, SEL_RGB, exp_rgb);
    apply_stimulus(11'd0, 11'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] exp_p;
    rst = 1'b1;
    bus.enable   = 1'b0;
    bus.btn_fire = 1'b0;
    apply_stimulus(11'd0, 11'd0, 1'b0, 1'b0);
    step(3);
    check_output("rst_power", SEL_POWER, 12'd0);
    check_output("rst_bar_on", SEL_ON, 12'd0);
    check_output("rst_rgb", SEL_RGB, 12'h000);
    check_output("rst_shot_valid", SEL_SVLD, 12'd0);
    check_output("rst_shot_power", SEL_SPWR, 12'd0);
    rst = 1'b0;
    step();

    // Geometry in IDLE (no fill).
    pix("border_tl", BAR_X, BAR_Y, 1'b0, 1'b0, 1'b1, 12'hFFF);
    pix("border_vblnk", BAR_X, BAR_Y, 1'b0, 1'b1, 1'b0, 12'h000);
    pix("border_hblnk", BAR_X, BAR_Y, 1'b1, 1'b0, 1'b0, 12'h000);
    pix("border_right", BAR_X + 11'd201, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b1, 12'hFFF);
    pix("past_right", BAR_X + 11'd202, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b0, 12'h000);
    pix("border_bottom", BAR_X + 11'd50, BAR_Y + 11'd15, 1'b0, 1'b0, 1'b1, 12'hFFF);
    pix("below_box", BAR_X + 11'd50, BAR_Y + 11'd16, 1'b0, 1'b0, 1'b0, 12'h000);
    pix("empty_interior", BAR_X + 11'd1, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b0, 12'h000);
    pix("left_of_box", BAR_X - 11'd1, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b0, 12'h000);

    // Press with enable low stays idle.
    bus.btn_fire = 1'b1;
    step();
    frame();
    frame();
    check_output("disabled_press_power", SEL_POWER, 12'd0);
    bus.btn_fire = 1'b0;
    step();

    // Hold for 120 frames: up to 100, then back down to 80.
    bus.enable   = 1'b1;
    bus.btn_fire = 1'b1;
    step();
    for (int f = 1; f <= 120; f++) begin
      frame();
      check_output($sformatf("charge_f%0d", f), SEL_POWER, (f <= 100) ? 12'(f) : 12'(200 - f));
    end
    pix("red_fill", BAR_X + 11'd1, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b1, 12'hF00);
    pix("red_last", BAR_X + 11'd160, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b1, 12'hF00);
    pix("red_past", BAR_X + 11'd161, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int f = 0; f < 38; f++) frame();
    check_output("down_to_42", SEL_POWER, 12'd42);
    pix("green_last", BAR_X + 11'd84, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b1, 12'h0F0);
    pix("green_past", BAR_X + 11'd85, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b0, 12'h000);

    // Release at 42: one pulse, then power holds for 60 frames.
    shot_q.push_back(7'd42);
    bus.btn_fire = 1'b0;
    step();
    check_output("rel42_valid", SEL_SVLD, 12'd1);
    check_output("rel42_power", SEL_SPWR, 12'd42);
    step();
    check_output("rel42_valid_low", SEL_SVLD, 12'd0);
    check_output("rel42_hold", SEL_SPWR, 12'd42);
    for (int f = 1; f <= 60; f++) begin
      if (f == 10) bus.btn_fire = 1'b1;
      if (f == 20) bus.btn_fire = 1'b0;
      frame();
      exp_p = (f < 60) ? 7'd42 : 7'd0;
      check_output($sformatf("show_f%0d", f), SEL_POWER, {5'd0, exp_p});
    end

    // Release coinciding with a tick at power 10.
    bus.btn_fire = 1'b1;
    step();
    for (int f = 0; f < 10; f++) frame();
    check_output("at_10", SEL_POWER, 12'd10);
    shot_q.push_back(7'd10);
    bus.btn_fire = 1'b0;
    bus.vblnk_in = 1'b1;
    step();
    check_output("rel10_valid", SEL_SVLD, 12'd1);
    check_output("rel10_power", SEL_SPWR, 12'd10);
    check_output("rel10_power_kept", SEL_POWER, 12'd10);
    bus.vblnk_in = 1'b0;
    step(2);
    check_output("rel10_after", SEL_POWER, 12'd10);
    for (int f = 0; f < 59; f++) frame();
    check_output("rel10_f59", SEL_POWER, 12'd10);
    frame();
    check_output("rel10_f60", SEL_POWER, 12'd0);

    // Reset mid-charge at 37: no pulse, everything cleared.
    bus.btn_fire = 1'b1;
    step();
    for (int f = 0; f < 37; f++) frame();
    check_output("at_37", SEL_POWER, 12'd37);
    pix("green37_last", BAR_X + 11'd74, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b1, 12'h0F0);
    pix("green37_past", BAR_X + 11'd75, BAR_Y + 11'd5, 1'b0, 1'b0, 1'b0, 12'h000);
    rst = 1'b1;
    step();
    check_output("midrst_power", SEL_POWER, 12'd0);
    check_output("midrst_valid", SEL_SVLD, 12'd0);
    check_output("midrst_shot_power", SEL_SPWR, 12'd0);
    check_output("midrst_bar_on", SEL_ON, 12'd0);
    bus.btn_fire = 1'b0;
    step();
    rst = 1'b0;
    step(2);
    frame();
    check_output("postrst_idle", SEL_POWER, 12'd0);

    // Power 50: yellow fill on pixels 1..100 of the row.
    bus.btn_fire = 1'b1;
    step();
    for (int f = 0; f < 50; f++) frame();
    check_output("at_50", SEL_POWER, 12'd50);
    for (int i = 1; i <= 101; i++) begin
      pix($sformatf("scan50_h%0d", i), BAR_X + 11'(i), BAR_Y + 11'd5, 1'b0, 1'b0,
          (i <= 100), (i <= 100) ? 12'hFF0 : 12'h000);
    end
    shot_q.push_back(7'd50);
    bus.btn_fire = 1'b0;
    step();
    check_output("rel50_power", SEL_SPWR, 12'd50);
    step(3);

    n_total++;
    if (shot_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL missing_shot: got %0d pending want 0", shot_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
